// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: owns the EX->MEM register, waits on data_sram_data_ok, and swallows stale responses of flushed accesses.
// Optional macro MEM_LOAD_EXT_EN: sub-word load lane select with sign/zero extension driven by ld_op.
module mem_stage_hs #(
    parameter  int PC_W        = 32,
    parameter  int RF_ADDR_W   = 5,
    parameter  int MAX_DISCARD = 3,
    localparam int SIG_W       = PC_W + RF_ADDR_W + 38,
    localparam int WB_W        = PC_W + RF_ADDR_W + 33,
    localparam int FWD_W       = RF_ADDR_W + 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             EX_valid,
    input  logic [SIG_W-1:0] EX_signal,
    input  logic             WB_allowin,
    input  logic             flush,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata,
    output logic             MEM_allowin,
    output logic             WB_signal_valid,
    output logic [WB_W-1:0]  WB_signal,
    output logic             ld_MEM,
    output logic [FWD_W-1:0] MEM_fwd,
    output logic             discard_busy
);

    localparam int CNT_W     = (MAX_DISCARD < 1) ? 1 : $clog2(MAX_DISCARD + 1);
    localparam int LDOP_LSB  = 32;
    localparam int WADDR_LSB = 35;
    localparam int WE_BIT    = WADDR_LSB + RF_ADDR_W;
    localparam int REQ_BIT   = WE_BIT + 1;
    localparam int RFM_BIT   = WE_BIT + 2;
    localparam int PC_LSB    = WE_BIT + 3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   discard_cnt_q, discard_cnt_d;
    logic [31:0]        rdata_buf_q, rdata_buf_d;

    logic                 valid;
    logic                 ready_go;
    logic                 data_ok_acc;
    logic                 cnt_inc;
    logic                 cnt_dec;
    logic [PC_W-1:0]      pc;
    logic                 res_from_mem;
    logic                 rf_we;
    logic [RF_ADDR_W-1:0] rf_waddr;
    logic [2:0]           ld_op;
    logic [31:0]          alu_result;
    logic [31:0]          rdata_sel;
    logic [31:0]          load_ext;
    logic [31:0]          final_result;

    assign pc           = sig_q[PC_LSB +: PC_W];
    assign res_from_mem = sig_q[RFM_BIT];
    assign rf_we        = sig_q[WE_BIT];
    assign rf_waddr     = sig_q[WADDR_LSB +: RF_ADDR_W];
    assign ld_op        = sig_q[LDOP_LSB +: 3];
    assign alu_result   = sig_q[31:0];

    // A response only belongs to this stage once every stale one has been swallowed.
    assign data_ok_acc  = data_sram_data_ok && (discard_cnt_q == '0);
    assign valid        = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            sig_q         <= '0;
            discard_cnt_q <= '0;
            rdata_buf_q   <= '0;
        end else begin
            state_q       <= state_d;
            sig_q         <= sig_d;
            discard_cnt_q <= discard_cnt_d;
            rdata_buf_q   <= rdata_buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (MEM_allowin) begin
            if (EX_valid) begin
                sig_d   = EX_signal;
                state_d = EX_signal[REQ_BIT] ? S_WAIT : S_HOLD;
            end else begin
                state_d = S_IDLE;
            end
        end else if (state_q == S_WAIT && data_ok_acc) begin
            state_d = S_HOLD;
        end
    end

    always_comb begin
        ready_go = 1'b0;
        case (state_q)
            S_HOLD:  ready_go = 1'b1;
            S_WAIT:  ready_go = data_ok_acc;
            default: ready_go = 1'b0;
        endcase
    end

    // Response arrived while WB stalls: keep it, since the bus will not repeat it.
    always_comb begin
        rdata_buf_d = rdata_buf_q;
        if (state_q == S_WAIT && data_ok_acc && !WB_allowin) begin
            rdata_buf_d = data_sram_rdata;
        end
    end

    // A flush of a still-waiting access leaves one response in flight that must be dropped.
    assign cnt_inc = flush && (state_q == S_WAIT) && !data_ok_acc;
    assign cnt_dec = data_sram_data_ok && (discard_cnt_q != '0);

    always_comb begin
        discard_cnt_d = discard_cnt_q;
        if (cnt_inc && !cnt_dec) begin
            if (discard_cnt_q != CNT_W'(MAX_DISCARD)) begin
                discard_cnt_d = discard_cnt_q + 1'b1;
            end
        end else if (cnt_dec && !cnt_inc) begin
            discard_cnt_d = discard_cnt_q - 1'b1;
        end
    end

    assign rdata_sel = (state_q == S_HOLD) ? rdata_buf_q : data_sram_rdata;

`ifdef MEM_LOAD_EXT_EN
    logic [7:0]  byte_lane [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = rdata_sel[8*gi +: 8];
        end
    endgenerate

    assign ld_byte = byte_lane[alu_result[1:0]];
    assign ld_half = alu_result[1] ? rdata_sel[31:16] : rdata_sel[15:0];

    always_comb begin
        load_ext = rdata_sel;
        case (ld_op)
            3'b001:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b101:  load_ext = {24'h0, ld_byte};
            3'b010:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b110:  load_ext = {16'h0, ld_half};
            default: load_ext = rdata_sel;
        endcase
    end
`else
    logic unused_ld_op;
    assign unused_ld_op = ^ld_op;
    assign load_ext     = rdata_sel;
`endif

    assign final_result    = res_from_mem ? load_ext : alu_result;

    assign MEM_allowin     = !valid || (ready_go && WB_allowin) || flush;
    assign WB_signal_valid = valid && ready_go && !flush;
    assign WB_signal       = {pc, rf_we, rf_waddr, final_result};
    assign ld_MEM          = valid && res_from_mem;
    assign MEM_fwd         = {valid && rf_we, ready_go, rf_waddr, final_result};
    assign discard_busy    = (discard_cnt_q != '0);

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs: a bus-level reference model predicts every handshake and result.
// Works with or without MEM_LOAD_EXT_EN defined.
module tb_mem_stage_hs;

    localparam int PC_W        = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int MAX_DISCARD = 3;
    localparam int SIG_W       = PC_W + RF_ADDR_W + 38;
    localparam int WB_W        = PC_W + RF_ADDR_W + 33;
    localparam int FWD_W       = RF_ADDR_W + 34;

    typedef struct {
        logic [PC_W-1:0]      pc;
        logic                 res_from_mem;
        logic                 req_issued;
        logic                 rf_we;
        logic [RF_ADDR_W-1:0] waddr;
        logic [2:0]           ld_op;
        logic [31:0]          alu;
        logic [31:0]          rdata;   // data the bus will return for this access
    } instr_t;

    typedef struct {
        logic [31:0] data;
        bit          stale;
    } resp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             EX_valid;
    logic [SIG_W-1:0] EX_signal;
    logic             WB_allowin;
    logic             flush;
    logic             data_ok;
    logic [31:0]      rdata;
    logic             MEM_allowin;
    logic             WB_signal_valid;
    logic [WB_W-1:0]  WB_signal;
    logic             ld_MEM;
    logic [FWD_W-1:0] MEM_fwd;
    logic             discard_busy;

    mem_stage_hs #(.PC_W(PC_W), .RF_ADDR_W(RF_ADDR_W), .MAX_DISCARD(MAX_DISCARD)) dut (
        .clk              (clk),
        .reset            (reset),
        .EX_valid         (EX_valid),
        .EX_signal        (EX_signal),
        .WB_allowin       (WB_allowin),
        .flush            (flush),
        .data_sram_data_ok(data_ok),
        .data_sram_rdata  (rdata),
        .MEM_allowin      (MEM_allowin),
        .WB_signal_valid  (WB_signal_valid),
        .WB_signal        (WB_signal),
        .ld_MEM           (ld_MEM),
        .MEM_fwd          (MEM_fwd),
        .discard_busy     (discard_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wb    = 0;

    logic [WB_W-1:0] exp_q[$];
    resp_t           bus_q[$];

    // Model: is an instruction held, and does it still owe a bus response.
    bit     occ     = 0;
    bit     waiting = 0;
    instr_t cur;

    // Expectations for the current cycle, consumed by the monitor.
    bit                   cyc_chk = 0;
    bit                   e_occ, e_allowin, e_wbv, e_ld, e_fwd_we, e_fwd_ready, e_busy;
    logic [RF_ADDR_W-1:0] e_waddr;
    logic [31:0]          e_result;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext_model(input instr_t i, input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * i.alu[1:0])) & 32'hFF;
        h = (d >> (16 * i.alu[1])) & 32'hFFFF;
`ifdef MEM_LOAD_EXT_EN
        case (i.ld_op)
            3'b001:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'b101:  return b;
            3'b010:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b110:  return h;
            default: return d;
        endcase
`else
        return d;
`endif
    endfunction

    function automatic logic [31:0] result_of(input instr_t i);
        return i.res_from_mem ? ext_model(i, i.rdata) : i.alu;
    endfunction

    function automatic logic [WB_W-1:0] wb_of(input instr_t i);
        return {i.pc, i.rf_we, i.waddr, result_of(i)};
    endfunction

    function automatic logic [SIG_W-1:0] pack(input instr_t i);
        return {i.pc, i.res_from_mem, i.req_issued, i.rf_we, i.waddr, i.ld_op, i.alu};
    endfunction

    function automatic instr_t mk(input logic [31:0] pc, input bit is_ld, input bit req, input bit we,
                                  input logic [RF_ADDR_W-1:0] wa, input logic [2:0] op,
                                  input logic [31:0] alu, input logic [31:0] rd);
        instr_t i;
        i.pc = pc; i.res_from_mem = is_ld; i.req_issued = req; i.rf_we = we;
        i.waddr = wa; i.ld_op = op; i.alu = alu; i.rdata = rd;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        int k;
        k = $urandom_range(0, 2);   // 0 alu, 1 load, 2 store
        return mk($urandom, (k == 1), (k != 0), (k == 2) ? 1'b0 : 1'($urandom),
                  RF_ADDR_W'($urandom), 3'($urandom), $urandom, $urandom);
    endfunction

    function automatic int stale_cnt();
        int s = 0;
        foreach (bus_q[i]) if (bus_q[i].stale) s++;
        return s;
    endfunction

    // One clock cycle: drive inputs, publish expectations, advance the model.
    task automatic step(input bit fl, input bit dok_en, input bit wba, input bit exv_in, input instr_t ni);
        bit dok, live, ready, exv;
        @(posedge clk); #1;
        exv   = exv_in && !fl;
        dok   = dok_en && (bus_q.size() > 0);
        live  = dok && !bus_q[0].stale;
        ready = occ && (!waiting || live);

        reset      = 1'b0;
        flush      = fl;
        WB_allowin = wba;
        EX_valid   = exv;
        EX_signal  = exv ? pack(ni) : pack(rand_instr());
        data_ok    = dok;
        rdata      = dok ? bus_q[0].data : $urandom;

        e_occ       = occ;
        e_allowin   = !occ || (ready && wba) || fl;
        e_wbv       = ready && !fl;
        e_ld        = occ && cur.res_from_mem;
        e_fwd_we    = occ && cur.rf_we;
        e_fwd_ready = ready;
        e_busy      = (stale_cnt() > 0);
        e_waddr     = cur.waddr;
        e_result    = result_of(cur);
        cyc_chk     = 1;

        if (dok) void'(bus_q.pop_front());
        if (live) waiting = 0;
        if (fl) begin
            if (occ && waiting) begin
                // The killed access still gets a response; only MAX_DISCARD of them are remembered.
                if (stale_cnt() < MAX_DISCARD) bus_q[bus_q.size()-1].stale = 1;
                else bus_q.delete(bus_q.size()-1);
            end
            if (occ) void'(exp_q.pop_back());
            occ     = 0;
            waiting = 0;
        end else if (e_allowin) begin
            occ = exv;
            if (exv) begin
                cur     = ni;
                waiting = ni.req_issued;
                if (ni.req_issued) bus_q.push_back('{data: ni.rdata, stale: 0});
                exp_q.push_back(wb_of(ni));
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        cyc_chk = 0;
        reset = 1'b1; flush = 1'b0; EX_valid = 1'b0; WB_allowin = 1'b0;
        data_ok = 1'b0; rdata = '0; EX_signal = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        occ = 0; waiting = 0; cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        bus_q.delete(); exp_q.delete();
        #1;
        chk("rst_allowin", MEM_allowin, 1);
        chk("rst_wb_valid", WB_signal_valid, 0);
        chk("rst_wb_signal", WB_signal, 0);
        chk("rst_ld_mem", ld_MEM, 0);
        chk("rst_fwd", MEM_fwd, 0);
        chk("rst_busy", discard_busy, 0);
    endtask

    // Monitor: per-cycle control outputs plus scoreboard pop on each WB handshake.
    always @(negedge clk) begin
        if (cyc_chk && !reset) begin
            chk("allowin", MEM_allowin, e_allowin);
            chk("wb_valid", WB_signal_valid, e_wbv);
            chk("ld_mem", ld_MEM, e_ld);
            chk("fwd_we", MEM_fwd[FWD_W-1], e_fwd_we);
            chk("fwd_ready", MEM_fwd[FWD_W-2], e_fwd_ready);
            chk("discard_busy", discard_busy, e_busy);
            if (e_occ) chk("fwd_waddr", MEM_fwd[32 +: RF_ADDR_W], e_waddr);
            if (e_fwd_ready) chk("fwd_result", MEM_fwd[31:0], e_result);
            if (WB_signal_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wb_unexpected: got %0h expected no output", WB_signal);
                end else if (WB_allowin) begin
                    chk("wb_signal", WB_signal, exp_q[0]);
                    void'(exp_q.pop_front());
                    n_wb++;
                    $display("[TB] wb #%0d pc=%h we=%0b waddr=%0d result=%h", n_wb,
                             WB_signal[WB_W-1 -: PC_W], WB_signal[WB_W-PC_W-1],
                             WB_signal[32 +: RF_ADDR_W], WB_signal[31:0]);
                end else begin
                    chk("wb_hold", WB_signal, exp_q[0]);
                end
            end
        end
    end

    initial begin
        instr_t ni, nx;
        bit fl, dok_en, wba, exv;

        reset = 1'b1; flush = 1'b0; EX_valid = 1'b0; WB_allowin = 1'b0;
        data_ok = 1'b0; rdata = '0; EX_signal = '0;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // ALU op: same-cycle WB hand-off
        ni = mk(32'h1000, 0, 0, 1, 5, 3'b000, 32'h1234, 0);
        step(0, 0, 1, 1, ni);
        step(0, 0, 1, 0, ni);

        // ld.b at ...03, data_ok three cycles after entry; signed and unsigned byte
        ni = mk(32'h1004, 1, 1, 1, 7, 3'b001, 32'h0000_0103, 32'h80FF_0000);
        step(0, 0, 1, 1, ni);
        repeat (3) step(0, 0, 1, 0, ni);
        step(0, 1, 1, 0, ni);
        ni = mk(32'h1008, 1, 1, 1, 8, 3'b101, 32'h0000_0103, 32'h80FF_0000);
        step(0, 0, 1, 1, ni);
        step(0, 1, 1, 0, ni);

        // WB back-pressure around a load response, next instruction enters on release
        ni = mk(32'h100C, 1, 1, 1, 9, 3'b000, 32'h0000_0200, 32'hDEAD_BEEF);
        nx = mk(32'h1010, 0, 0, 1, 10, 3'b000, 32'h0000_5555, 0);
        step(0, 0, 1, 1, ni);
        step(0, 1, 0, 1, nx);
        step(0, 0, 0, 1, nx);
        step(0, 0, 1, 1, nx);
        step(0, 0, 1, 0, nx);

        // Flush a waiting load; its late response must be swallowed
        ni = mk(32'h1014, 1, 1, 1, 11, 3'b000, 32'h0000_0300, 32'h1111_1111);
        nx = mk(32'h1018, 1, 1, 1, 12, 3'b000, 32'h0000_0304, 32'h2222_2222);
        step(0, 0, 1, 1, ni);
        step(0, 0, 1, 0, ni);
        step(1, 0, 1, 0, ni);
        step(0, 0, 1, 1, nx);
        step(0, 1, 1, 0, nx);
        step(0, 1, 1, 0, nx);

        // Four flushed waiting loads: counter saturates at MAX_DISCARD, then reset mid-WAIT
        for (int k = 0; k < 4; k++) begin
            ni = mk(32'h2000 + 32'(4*k), 1, 1, 1, 13, 3'b000, 32'h400, 32'hA0A0_0000 + 32'(k));
            step(0, 0, 1, 1, ni);
            step(1, 0, 1, 0, ni);
        end
        ni = mk(32'h2010, 1, 1, 1, 14, 3'b000, 32'h404, 32'h3333_3333);
        step(0, 0, 1, 1, ni);
        repeat (3) step(0, 1, 0, 0, ni);
        step(0, 0, 1, 0, ni);
        do_reset();

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            fl     = occ && ($urandom_range(0, 9) == 0);
            dok_en = ($urandom_range(0, 9) < 4);
            if (fl && waiting && stale_cnt() >= MAX_DISCARD) fl = 0;
            if (fl && waiting && dok_en && bus_q.size() > 0 && bus_q[0].stale) dok_en = 0;
            wba = ($urandom_range(0, 9) < 7);
            exv = !fl && ($urandom_range(0, 9) < 6);
            step(fl, dok_en, wba, exv, rand_instr());
        end

        // Drain everything still in flight
        for (int c = 0; c < 20; c++) step(0, 1, 1, 0, rand_instr());
        @(posedge clk); #1;
        cyc_chk = 0;
        chk("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Parametrised successor to the single-cycle memory-access stage of the five-stage pipeline. It owns its own EX→MEM pipeline register and waits on an SRAM-style `data_ok` response, so loads may take any number of cycles. It extracts and extends sub-word load data, and cleanly discards responses that belong to flushed instructions. It sits between the EX stage (producer) and the WB stage (consumer) and drives MEM→ID forwarding.

## Interface
Parameters:
- `PC_W`, 32, PC width.
- `RF_ADDR_W`, 5, register-file address width.
- `MAX_DISCARD`, 3, maximum stale responses to swallow after flushes; counter width is `$clog2(MAX_DISCARD+1)`.

Ports (SIG_W = PC_W+RF_ADDR_W+38; WB_W = PC_W+RF_ADDR_W+33):
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `EX_valid` in 1: EX offers an instruction.
- `EX_signal` in SIG_W: `{pc, res_from_mem, req_issued, rf_we, rf_waddr, ld_op[2:0], alu_result[31:0]}`.
- `WB_allowin` in 1: WB can accept this cycle.
- `flush` in 1: kill the instruction held in MEM (exception/ertn from WB).
- `data_sram_data_ok` in 1: read/write response strobe.
- `data_sram_rdata` in 32: response data, valid with `data_ok`.
- `MEM_allowin` out 1: MEM accepts `EX_signal` this cycle.
- `WB_signal_valid` out 1: `WB_signal` is valid.
- `WB_signal` out WB_W: `{pc, rf_we, rf_waddr, final_result}`.
- `ld_MEM` out 1: `valid && res_from_mem`.
- `MEM_fwd` out RF_ADDR_W+34: `{fwd_we, fwd_ready, rf_waddr, final_result}`.
- `discard_busy` out 1: discard counter is non-zero.

## Operation
- Stage register `valid`, `sig`: on `MEM_allowin`, load `valid <= EX_valid` and capture `sig` when `EX_valid`. `flush` clears `valid` next cycle, with priority over everything except `reset`.
- State `{IDLE, WAIT, HOLD}`:
  - IDLE: `valid=0`.
  - On entry, go to WAIT if `req_issued`, otherwise go to HOLD. Stores also set `req_issued` and wait for their `data_ok`.
  - WAIT → HOLD on an accepted `data_ok`.
  - HOLD → IDLE/next state on `WB_allowin`.
- Accepted `data_ok` means `data_ok && discard_cnt==0`. When `discard_cnt>0`, a `data_ok` decrements the counter and is ignored by the stage.
- `ready_go`:
  - HOLD: 1.
  - WAIT: 1 only when an accepted `data_ok` arrives this cycle; `rdata` is bypassed combinationally.
  - Otherwise 0.
- On an accepted `data_ok` with `WB_allowin=0`, `rdata` is latched into `rdata_buf` and used while in HOLD.
- `MEM_allowin = !valid || (ready_go && WB_allowin) || flush`.
- `WB_signal_valid = valid && ready_go && !flush`.
- `final_result = res_from_mem ? ext(rdata_sel) : alu_result`.
- `ext()` uses `ld_op`, with lane selected by `alu_result[1:0]`:
  - 000: word.
  - 001: byte, sign-extended.
  - 101: byte, zero-extended.
  - 010: half, sign-extended.
  - 110: half, zero-extended.
  - Other codes behave as word.
- Half-word lane uses `alu_result[1]`; `alu_result[0]` is ignored.
- `fwd_we = valid && rf_we`; `fwd_ready = ready_go`.
- Flush while in WAIT without `data_ok` that cycle: `discard_cnt` increments, saturating at `MAX_DISCARD`. Flush in the same cycle as an accepted `data_ok`: no increment.
- Reset: `valid=0`, state IDLE, `discard_cnt=0`, `rdata_buf=0`, `sig=0`. All outputs are 0 except `MEM_allowin=1`.

## Timing
- Non-memory instruction: enters at edge N, `WB_signal_valid` at cycle N; zero added latency.
- Load: `WB_signal_valid` rises in the same cycle as the accepted `data_ok`. Latency is 0 cycles after `data_ok`.
- WB back-pressure: outputs are held stable, and `MEM_allowin=0`, until `WB_allowin`.
- Back-to-back: a new instruction enters in the same edge that the old one leaves.
- Reset mid-WAIT drops state and discard counter; the bus is reset together with the stage.

## Configuration
- `MEM_LOAD_EXT_EN` defined: sub-word select and extension as above.
- Undefined: `ld_op` is ignored, `final_result` is the raw 32-bit `rdata` for loads, and the extension logic is absent.

## Test plan
- ALU op `rf_we=1`, `waddr=5`, `alu_result=0x1234`, `WB_allowin=1` → same-cycle `WB_signal_valid=1`, `WB_signal` result `0x1234`.
- ld.b at addr `...03`; `data_ok` 3 cycles later with `rdata=0x80FF_0000` → result `0xFFFF_FF80`. With `ld_op`=101 → `0x0000_0080`. With the macro off → `0x80FF_0000`.
- Load; `data_ok` arrives with `WB_allowin=0` for 2 cycles, `rdata=0xDEADBEEF` → `MEM_allowin=0` and result held at `0xDEADBEEF`; WB accepts on cycle 3, and a new instruction enters on the same edge.
- Load in WAIT, flush → next cycle `valid=0`, `discard_busy=1`. A new load enters; the first `data_ok` (`0x1111_1111`) is ignored; the second `data_ok` (`0x2222_2222`) → result `0x2222_2222`.
- Three flushes of waiting loads with `MAX_DISCARD=3` → counter reads 3 and saturates on a fourth; `reset` asserted mid-WAIT → counter 0, `MEM_allowin=1` next cycle.
